// File: rtl/ans_preamble_pkg.sv
// ============================================================================
// ans_preamble_pkg : shared types and constants for the legacy preamble sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package ans_preamble_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STF  = 2'd1,
      S_LTF  = 2'd2
   } state_t;

   // Preamble geometry at the default configuration.
   localparam int STF_LEN      = 160;
   localparam int LTF_LEN      = 160;
   localparam int PREAMBLE_LEN = 320;
   localparam int LTF_ADDR_OFS = 128;

endpackage

`default_nettype wire

// File: rtl/ans_iq_avg2.sv
// ============================================================================
// ans_iq_avg2 : per-component halving / averaging of packed {I,Q} samples,
// compiled only when ANS_PREAMBLE_WIN_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

`ifdef ANS_PREAMBLE_WIN_EN
module ans_iq_avg2 #(
   parameter int IQ_W = 16
) (
   input  logic [2*IQ_W-1:0] a,
   input  logic [2*IQ_W-1:0] b,
   output logic [2*IQ_W-1:0] half_a,
   output logic [2*IQ_W-1:0] avg_ab
);

   // Component 1 is I (upper half), component 0 is Q (lower half).
   for (genvar c = 0; c < 2; c++) begin : g_comp
      logic [IQ_W-1:0] ac;
      logic [IQ_W-1:0] bc;
      logic [IQ_W:0]   sum;

      assign ac  = a[c*IQ_W +: IQ_W];
      assign bc  = b[c*IQ_W +: IQ_W];
      assign sum = {ac[IQ_W-1], ac} + {bc[IQ_W-1], bc};

      assign half_a[c*IQ_W +: IQ_W] = {ac[IQ_W-1], ac[IQ_W-1:1]};
      assign avg_ab[c*IQ_W +: IQ_W] = sum[IQ_W:1];
   end

endmodule
`endif

`default_nettype wire

// File: rtl/ans_l_preamble_seq.sv
// ============================================================================
// ans_l_preamble_seq : sequences the 320-sample L-STF + L-LTF preamble onto a
// valid/ready stream. Optional edge windowing: ANS_PREAMBLE_WIN_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ans_l_preamble_seq
   import ans_preamble_pkg::*;
#(
   parameter int STF_REPS   = 10,
   parameter int LTF_GI_LEN = 32,
   parameter int IQ_W       = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [3:0]        stf_addr,
   input  logic [2*IQ_W-1:0] stf_symbol,
   output logic [5:0]        ltf_addr,
   input  logic [2*IQ_W-1:0] ltf_symbol,
   output logic [2*IQ_W-1:0] out_sample,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int STF_SAMPLES = STF_REPS * 16;
   localparam int LAST_IDX    = STF_SAMPLES + LTF_LEN - 1;
   localparam int LTF_OFS     = STF_SAMPLES - LTF_GI_LEN;

   state_t            state;
   logic [8:0]        idx;
   logic              last_pending;
   logic              load;
   logic [2*IQ_W-1:0] sel_sample;

   assign load = (state != S_IDLE) && (!out_valid || out_ready);

   // Only the low 6 bits of (idx - offset) matter, so subtract on 6 bits.
   assign stf_addr = (state == S_STF) ? idx[3:0] : 4'd0;
   assign ltf_addr = (state == S_LTF) ? (idx[5:0] - 6'(LTF_OFS % 64)) : 6'd0;

   // last_pending marks that out_sample holds the final preamble sample.
   assign done = out_valid && out_ready && last_pending;

`ifdef ANS_PREAMBLE_WIN_EN
   logic [2*IQ_W-1:0] stf_half;
   logic [2*IQ_W-1:0] seam_avg;

   ans_iq_avg2 #(.IQ_W(IQ_W)) u_avg (
      .a      (stf_symbol),
      .b      (ltf_symbol),
      .half_a (stf_half),
      .avg_ab (seam_avg)
   );

   always_comb begin
      sel_sample = (state == S_STF) ? stf_symbol : ltf_symbol;
      if (state == S_STF && idx == 9'd0)
         sel_sample = stf_half;
      else if (state == S_LTF && idx == 9'(STF_SAMPLES))
         sel_sample = seam_avg;
   end
`else
   assign sel_sample = (state == S_STF) ? stf_symbol : ltf_symbol;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         idx          <= 9'd0;
         out_sample   <= '0;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
         last_pending <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // busy stays high until the last sample is taken, so a start
               // coinciding with done is ignored.
               if (start && !busy) begin
                  state <= S_STF;
                  busy  <= 1'b1;
                  idx   <= 9'd0;
               end
            end
            default: begin
               if (load) begin
                  idx <= idx + 9'd1;
                  if (state == S_STF && idx == 9'(STF_SAMPLES - 1))
                     state <= S_LTF;
                  if (state == S_LTF && idx == 9'(LAST_IDX)) begin
                     state <= S_IDLE;
                     idx   <= 9'd0;
                  end
               end
            end
         endcase

         if (load) begin
            out_sample   <= sel_sample;
            out_valid    <= 1'b1;
            last_pending <= (idx == 9'(LAST_IDX));
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (done) begin
            busy         <= 1'b0;
            last_pending <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/ans_l_preamble_seq.md
Name: ans_l_preamble_seq

Overview:
- Sequences the full 802.11a/g legacy preamble (L-STF followed by L-LTF) as a 320-sample I/Q stream.
- Drives the 4-bit address of the combinational L-STF generator and the 6-bit address of the L-LTF ROM, then registers the selected sample onto a valid/ready output.
- Sits between the TX controller (start) and the IFFT-bypass/CP output mux of the openofdm_tx datapath.

Parameters:
- STF_REPS, 10, number of 16-sample L-STF periods emitted.
- LTF_GI_LEN, 32, length of the L-LTF double guard interval (fixed 32; only the default is supported).
- IQ_W, 16, width of each of I and Q; samples are {I,Q}, 2*IQ_W bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a preamble; ignored while busy=1
- stf_addr  out  4  address to the L-STF generator; combinational from the counter
- stf_symbol  in  32  {I,Q} returned by the L-STF generator in the same cycle
- ltf_addr  out  6  address to the L-LTF ROM; combinational from the counter
- ltf_symbol  in  32  {I,Q} returned by the L-LTF ROM in the same cycle
- out_sample  out  32  registered {I,Q} preamble sample
- out_valid  out  1  out_sample holds a valid sample
- out_ready  in  1  downstream accepts out_sample when out_valid and out_ready are both 1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse on the cycle the final (320th) sample is accepted

Behaviour:
- Reset: state=IDLE, idx=0, out_sample=0, out_valid=0, busy=0, done=0, stf_addr=0, ltf_addr=0.
- States: IDLE -> STF (idx 0..159) -> LTF (idx 160..319) -> IDLE.
- idx is 9 bits, unsigned.
- load = (state!=IDLE) && (!out_valid || out_ready).
- On each load cycle: the output register captures the selected sample, out_valid<=1, and idx increments.
- STF: stf_addr=idx[3:0]; selected sample is stf_symbol.
- LTF: ltf_addr=(idx-128)[5:0], which gives 32..63 for the guard interval, then 0..63 twice; selected sample is ltf_symbol.
- Transition STF->LTF when idx=159 is loaded. Transition LTF->IDLE when idx=319 is loaded.
- IDLE with start=1: go to STF, busy<=1, idx=0. The first load happens in the next cycle, so out_valid rises 2 cycles after start.
- When out_valid && out_ready and no load is performed (state IDLE): out_valid<=0.
- done=1 for exactly the cycle in which sample 319 is accepted downstream; busy<=0 in that same cycle.
- Backpressure: while out_valid && !out_ready, out_sample, idx and both addresses hold.
- Throughput is 1 sample/cycle under continuous ready.
- start asserted while busy has no effect. start in the same cycle as done is also ignored; the next start is accepted from IDLE only.
- Reset mid-preamble aborts immediately to the reset values; no done pulse is generated.
- Outside its active state, each address output is 0.

Optional Feature:
- ANS_PREAMBLE_WIN_EN defined: apply edge windowing.
  - idx 0: output is (stf_symbol I>>>1, Q>>>1), arithmetic shift, per component.
  - idx 160: stf_addr is forced to 0 and the output is per-component (stf+ltf)>>>1. The sum is computed at IQ_W+1 bits; the result is truncated to IQ_W.
  - All other samples are unchanged.
- Not defined: no windowing; every sample passes through unmodified, and stf_addr is 0 during LTF.

Decomposition:
- Shared package ans_preamble_pkg holds:
  - state enum {S_IDLE, S_STF, S_LTF};
  - localparams STF_LEN=160, LTF_LEN=160, PREAMBLE_LEN=320, LTF_ADDR_OFS=128.
- Optional sub-module ans_iq_avg2: combinational per-component halving/averaging, used only under ANS_PREAMBLE_WIN_EN. Everything else stays flat.

Test Plan:
- Sanity: reset, then start, out_ready=1 constant.
  - out_valid rises 2 cycles after start.
  - Exactly 320 consecutive samples.
  - stf_addr sequence 0..15 repeated 10x.
  - ltf_addr 32..63, 0..63, 0..63.
  - done single pulse with sample 319; busy falls the same cycle.
- Backpressure: toggle out_ready pseudo-randomly (~50%) with ROM models returning {idx-tagged} data.
  - The accepted stream is identical to the no-backpressure run.
  - out_sample is stable while stalled.
- Redundant start: start pulses at samples 5 and 200 of a run.
  - Still exactly 320 samples and one done.
  - start one cycle after done begins a new run normally.
- Reset at sample 100: all outputs return to reset values the next cycle, with no done pulse. A fresh start then yields stf_addr=0 first.
- Window (ANS_PREAMBLE_WIN_EN): STF ROM addr0={I=0x0200,Q=0xFE00}, LTF addr32={I=0x0100,Q=0x0100}.
  - Sample 0 = {0x0100,0xFF00}.
  - Sample 160 = {0x0180,0xFF80}.
  - Sample 1 is unmodified.
